// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and holds
// the IF/ID register, absorbing stalls and redirects (including mid-request ones).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [5:0]  out_Op,
   output logic [5:0]  out_Func
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] tgt_pc_q, tgt_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_instr_q, id_instr_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic [31:0] redir_pc;
   logic        flush;

   assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      state_d      = state_q;
      req_pc_d     = req_pc_q;
      tgt_pc_d     = tgt_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      id_valid_d   = id_valid_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pc4_d     = id_pc4_q;
      flush        = 1'b0;
      case (state_q)
         FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  req_pc_d = redir_pc;
                  flush    = 1'b1;
               end else if (stall && id_valid_q) begin
                  skid_instr_d = imem_rdata;
                  skid_pc_d    = req_pc_q;
                  req_pc_d     = pc_inc(req_pc_q);
                  state_d      = HOLD;
               end else begin
                  id_valid_d = 1'b1;
                  id_instr_d = imem_rdata;
                  id_pc_d    = req_pc_q;
                  id_pc4_d   = pc_inc(req_pc_q);
                  req_pc_d   = pc_inc(req_pc_q);
               end
            end else if (redirect) begin
               // Keep req_pc so the outstanding address stays stable until ack.
               tgt_pc_d = redir_pc;
               state_d  = DROP;
               flush    = 1'b1;
            end else if (!stall) begin
               id_valid_d = 1'b0;
               id_instr_d = NOP_WORD;
            end
         end
         DROP: begin
            flush = 1'b1;
            if (imem_ack) begin
               req_pc_d = redirect ? redir_pc : tgt_pc_q;
               state_d  = FETCH;
            end else if (redirect) begin
               tgt_pc_d = redir_pc;
            end
         end
         HOLD: begin
            if (redirect) begin
               req_pc_d = redir_pc;
               flush    = 1'b1;
               state_d  = FETCH;
            end else if (!stall) begin
               id_valid_d = 1'b1;
               id_instr_d = skid_instr_q;
               id_pc_d    = skid_pc_q;
               id_pc4_d   = pc_inc(skid_pc_q);
               state_d    = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
      if (flush) begin
         id_valid_d = 1'b0;
         id_instr_d = NOP_WORD;
      end
      req_d = (state_d != HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         req_q        <= 1'b1;
         req_pc_q     <= RESET_PC;
         skid_instr_q <= NOP_WORD;
         skid_pc_q    <= 32'd0;
         id_valid_q   <= 1'b0;
         id_instr_q   <= NOP_WORD;
         id_pc_q      <= 32'd0;
         id_pc4_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         req_pc_q     <= req_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_pc4_q     <= id_pc4_d;
      end
   end

   // Redirect target is always written before DROP reads it.
   always_ff @(posedge clk) begin
      tgt_pc_q <= tgt_pc_d;
   end

   assign imem_req  = req_q;
   assign imem_addr = req_pc_q;
   assign id_valid  = id_valid_q;
   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign id_pc4    = id_pc4_q;
   assign out_Op    = id_instr_q[31:26];
   assign out_Func  = id_instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized req/ack/stall/redirect
// traffic compared every cycle against a queue-based behavioural model.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic [5:0]  out_Op;
   logic [5:0]  out_Func;

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
      .out_Op(out_Op), .out_Func(out_Func)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   // Model: next fetch address, pending-discard flag with its target,
   // a buffer of fetched-but-not-yet-issued words, and the ID slot.
   logic [31:0] m_pc;
   bit          m_drop;
   logic [31:0] m_tgt;
   ent_t        m_buf[$];
   bit          m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_id_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h2408_0005;
      if (a == 32'h0000_3004) return 32'h0109_5020;
      return ((a ^ 32'h5BD1_E995) * 32'h2545_F491) ^ (a >> 7);
   endfunction

   function automatic bit m_req();
      return (m_buf.size() == 0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_flush();
      m_valid = 1'b0;
      m_instr = NOP_WORD;
   endtask

   task automatic m_issue(input logic [31:0] instr, input logic [31:0] pc);
      m_valid = 1'b1;
      m_instr = instr;
      m_id_pc = pc;
   endtask

   task automatic model_update(input bit r, input bit a, input bit s, input bit d,
                               input logic [31:0] t);
      logic [31:0] ta;
      ta = {t[31:2], 2'b00};
      if (r) begin
         m_pc = RESET_PC; m_drop = 0; m_buf.delete();
         m_valid = 0; m_instr = NOP_WORD; m_id_pc = 32'd0;
      end else if (m_buf.size() != 0) begin
         if (d) begin
            m_buf.delete(); m_pc = ta; m_flush();
         end else if (!s) begin
            m_issue(m_buf[0].instr, m_buf[0].pc);
            void'(m_buf.pop_front());
         end
      end else if (m_drop) begin
         m_flush();
         if (a) begin
            m_pc = d ? ta : m_tgt; m_drop = 0;
         end else if (d) begin
            m_tgt = ta;
         end
      end else if (a) begin
         if (d) begin
            m_pc = ta; m_flush();
         end else if (s && m_valid) begin
            m_buf.push_back('{instr: mem_word(m_pc), pc: m_pc});
            m_pc = m_pc + 32'd4;
         end else begin
            m_issue(mem_word(m_pc), m_pc);
            m_pc = m_pc + 32'd4;
         end
      end else if (d) begin
         m_tgt = ta; m_drop = 1; m_flush();
      end else if (!s) begin
         m_flush();
      end
   endtask

   task automatic check_all();
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
      chk("imem_addr", imem_addr, m_pc);
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("id_instr", id_instr, m_instr);
      chk("out_Op", {26'd0, out_Op}, {26'd0, m_instr[31:26]});
      chk("out_Func", {26'd0, out_Func}, {26'd0, m_instr[5:0]});
      if (m_valid) begin
         chk("id_pc", id_pc, m_id_pc);
         chk("id_pc4", id_pc4, m_id_pc + 32'd4);
      end
   endtask

   // One clock: drive inputs, advance model at the edge, check #1 later.
   task automatic step(input bit r, input bit a, input bit s, input bit d,
                       input logic [31:0] t);
      bit a_eff;
      a_eff       = r ? a : (a && m_req());
      reset       = r;
      imem_ack    = a_eff;
      stall       = s;
      redirect    = d;
      redirect_pc = t;
      imem_rdata  = a_eff ? mem_word(imem_addr) : $urandom();
      @(posedge clk);
      model_update(r, a_eff, s, d, t);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      m_pc = RESET_PC; m_drop = 0; m_tgt = '0;
      m_valid = 0; m_instr = NOP_WORD; m_id_pc = '0;

      // Reset with ack asserted: ack must be ignored
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("rst_req", {31'd0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, 32'h3000);
      chk("rst_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_pc4", id_pc4, 32'd0);

      // Zero-wait streaming
      step(0, 1, 0, 0, 0);
      chk("s1_instr", id_instr, 32'h2408_0005);
      chk("s1_pc", id_pc, 32'h3000);
      chk("s1_addr", imem_addr, 32'h3004);
      step(0, 1, 0, 0, 0);
      chk("s2_instr", id_instr, 32'h0109_5020);
      chk("s2_func", {26'd0, out_Func}, 32'h20);
      chk("s2_addr", imem_addr, 32'h3008);

      // Two-cycle stall with skid capture
      step(0, 1, 1, 0, 0);
      chk("st1_pc", id_pc, 32'h3004);
      chk("st1_req", {31'd0, imem_req}, 32'd0);
      step(0, 1, 1, 0, 0);
      chk("st2_pc", id_pc, 32'h3004);
      step(0, 1, 0, 0, 0);
      chk("st3_pc", id_pc, 32'h3008);
      step(0, 1, 0, 0, 0);
      chk("st4_pc", id_pc, 32'h300C);
      chk("st4_addr", imem_addr, 32'h3010);

      // Redirect while request outstanding
      step(0, 0, 0, 1, 32'h3400);
      chk("dr1_addr", imem_addr, 32'h3010);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("dr2_addr", imem_addr, 32'h3010);
      chk("dr2_valid", {31'd0, id_valid}, 32'd0);
      step(0, 1, 0, 0, 0);
      chk("dr3_addr", imem_addr, 32'h3400);
      chk("dr3_valid", {31'd0, id_valid}, 32'd0);
      step(0, 1, 0, 0, 0);
      chk("dr4_pc", id_pc, 32'h3400);

      // Redirect overrides stall
      step(0, 1, 1, 1, 32'h3800);
      chk("rs_valid", {31'd0, id_valid}, 32'd0);
      chk("rs_instr", id_instr, 32'd0);
      chk("rs_addr", imem_addr, 32'h3800);

      // Alignment and wrap
      step(0, 1, 0, 1, 32'h3403);
      chk("al_addr", imem_addr, 32'h3400);
      step(0, 1, 0, 1, 32'hFFFF_FFFC);
      chk("wr1_addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 1, 0, 0, 0);
      chk("wr2_addr", imem_addr, 32'h0);
      chk("wr2_pc4", id_pc4, 32'h0);

      // Reset during DROP with a coincident ack
      step(0, 0, 0, 1, 32'h5000);
      step(1, 1, 0, 0, 0);
      chk("rd_addr", imem_addr, 32'h3000);
      chk("rd_pc", id_pc, 32'h0);
      chk("rd_valid", {31'd0, id_valid}, 32'd0);
      step(0, 1, 0, 0, 0);
      chk("rd2_instr", id_instr, 32'h2408_0005);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit r, a, s, d;
         logic [31:0] t;
         r = ($urandom_range(0, 299) == 0);
         a = ($urandom_range(0, 99) < 60);
         s = ($urandom_range(0, 99) < 25);
         d = ($urandom_range(0, 99) < 8);
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                         : $urandom();
         step(r, a, s, d, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
